// File: rtl/state_dump_reader_pkg.sv
// Shared encodings for the post-run state dump: FSM states, beat kinds and the
// word-to-byte address shift. The core's read-port mux uses the same constants.
package state_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REG_RD  = 3'd1,
        ST_REG_OUT = 3'd2,
        ST_MEM_RD  = 3'd3,
        ST_MEM_OUT = 3'd4,
        ST_FIN     = 3'd5
    } dump_state_e;

    localparam logic DUMP_KIND_REG = 1'b0;
    localparam logic DUMP_KIND_MEM = 1'b1;
    localparam int   WORD_SHIFT    = 2;

endpackage

// File: rtl/state_dump_reader.sv
// Walks the register file then data memory of a halted core and streams each
// entry out as a (kind, index, data) beat on a valid/ready port.
module state_dump_reader
    import state_dump_reader_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int MEM_WORDS = 64,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             dumpOwn,
    output logic [4:0]       dumpRegAddr,
    input  logic [31:0]      regRdData,
    output logic [31:0]      dumpMemAddr,
    output logic             dumpMemRead,
    output logic             dumpFullWord,
    input  logic [31:0]      memRdData,
    output logic             dumpValid,
    input  logic             dumpReady,
    output logic             dumpKind,
    output logic [IDX_W-1:0] dumpIndex,
    output logic [31:0]      dumpData,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

    dump_state_e      r_state;
    logic [IDX_W-1:0] r_idx;
    dump_state_e      w_nstate;
    logic [IDX_W-1:0] w_nidx;

    // *_OUT states always present a valid beat, so dumpReady alone is the accept.
    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        if (abort) begin
            w_nstate = ST_IDLE;
            w_nidx   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_nstate = ST_REG_RD;
                        w_nidx   = '0;
                    end
                end
                ST_REG_RD:  w_nstate = ST_REG_OUT;
                ST_REG_OUT: begin
                    if (dumpReady) begin
                        if (r_idx == LAST_REG) begin
                            w_nidx   = '0;
                            w_nstate = ST_MEM_RD;
                        end else begin
                            w_nidx   = r_idx + 1'b1;
                            w_nstate = ST_REG_RD;
                        end
                    end
                end
                ST_MEM_RD:  w_nstate = ST_MEM_OUT;
                ST_MEM_OUT: begin
                    if (dumpReady) begin
                        if (r_idx == LAST_MEM) begin
                            w_nstate = ST_FIN;
                        end else begin
                            w_nidx   = r_idx + 1'b1;
                            w_nstate = ST_MEM_RD;
                        end
                    end
                end
                ST_FIN: begin
                    w_nstate = ST_IDLE;
                    w_nidx   = '0;
                end
                default: begin
                    w_nstate = ST_IDLE;
                    w_nidx   = '0;
                end
            endcase
        end
    end

    // Flags and read addresses are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            busy         <= 1'b0;
            dumpOwn      <= 1'b0;
            dumpRegAddr  <= '0;
            dumpMemAddr  <= '0;
            dumpMemRead  <= 1'b0;
            dumpFullWord <= 1'b0;
            dumpValid    <= 1'b0;
            dumpKind     <= 1'b0;
            dumpIndex    <= '0;
            dumpData     <= '0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_nstate;
            r_idx        <= w_nidx;
            busy         <= (w_nstate != ST_IDLE);
            dumpOwn      <= (w_nstate inside {ST_REG_RD, ST_REG_OUT, ST_MEM_RD, ST_MEM_OUT});
            dumpFullWord <= (w_nstate inside {ST_REG_RD, ST_REG_OUT, ST_MEM_RD, ST_MEM_OUT});
            dumpRegAddr  <= (w_nstate == ST_REG_RD) ? w_nidx[4:0] : 5'd0;
            dumpMemAddr  <= (w_nstate == ST_MEM_RD) ? (32'(w_nidx) << WORD_SHIFT) : 32'd0;
            dumpMemRead  <= (w_nstate == ST_MEM_RD);
            dumpValid    <= (w_nstate inside {ST_REG_OUT, ST_MEM_OUT});
            done         <= (w_nstate == ST_FIN);
            if (!abort && r_state == ST_REG_RD) begin
                dumpData  <= regRdData;
                dumpIndex <= r_idx;
                dumpKind  <= DUMP_KIND_REG;
            end else if (!abort && r_state == ST_MEM_RD) begin
                dumpData  <= memRdData;
                dumpIndex <= r_idx;
                dumpKind  <= DUMP_KIND_MEM;
            end
        end
    end

endmodule

// File: tb/tb_state_dump_reader.sv
// Scoreboard bench: a 32/64 dump instance for the main scenarios and a 1/1
// instance for the minimum-size corner, each with a combinational memory model.
module tb_state_dump_reader;
    import state_dump_reader_pkg::*;

    typedef struct packed {
        logic        kind;
        logic [7:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic clk;
    logic [31:0] rf  [32];
    logic [31:0] mem [64];

    logic b_rstn, b_start, b_abort, b_busy, b_own, b_mrd, b_full, b_valid, b_ready, b_kind, b_done;
    logic [4:0]  b_raddr;
    logic [31:0] b_maddr, b_rrd, b_mrdd, b_data;
    logic [7:0]  b_index;
    logic s_rstn, s_start, s_abort, s_busy, s_own, s_mrd, s_full, s_valid, s_ready, s_kind, s_done;
    logic [4:0]  s_raddr;
    logic [31:0] s_maddr, s_rrd, s_mrdd, s_data;
    logic [7:0]  s_index;

    assign b_rrd  = rf[b_raddr];
    assign b_mrdd = mem[b_maddr[7:2]];
    assign s_rrd  = rf[s_raddr];
    assign s_mrdd = mem[s_maddr[7:2]];

    state_dump_reader #(.NUM_REGS(32), .MEM_WORDS(64), .IDX_W(8)) u_big (
        .clk(clk), .resetN(b_rstn), .start(b_start), .abort(b_abort), .busy(b_busy),
        .dumpOwn(b_own), .dumpRegAddr(b_raddr), .regRdData(b_rrd), .dumpMemAddr(b_maddr),
        .dumpMemRead(b_mrd), .dumpFullWord(b_full), .memRdData(b_mrdd), .dumpValid(b_valid),
        .dumpReady(b_ready), .dumpKind(b_kind), .dumpIndex(b_index), .dumpData(b_data),
        .done(b_done));

    state_dump_reader #(.NUM_REGS(1), .MEM_WORDS(1), .IDX_W(8)) u_small (
        .clk(clk), .resetN(s_rstn), .start(s_start), .abort(s_abort), .busy(s_busy),
        .dumpOwn(s_own), .dumpRegAddr(s_raddr), .regRdData(s_rrd), .dumpMemAddr(s_maddr),
        .dumpMemRead(s_mrd), .dumpFullWord(s_full), .memRdData(s_mrdd), .dumpValid(s_valid),
        .dumpReady(s_ready), .dumpKind(s_kind), .dumpIndex(s_index), .dumpData(s_data),
        .done(s_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    errors = 0;
    int    checks = 0;
    int    nb = 0;
    int    ns = 0;
    beat_t qb[$];
    beat_t qs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_big_zero(input string name);
        chk({name, "_flags"}, {b_busy, b_own, b_raddr, b_mrd, b_full, b_valid, b_kind, b_done, b_index}, 64'd0);
        chk({name, "_maddr"}, b_maddr, 64'd0);
        chk({name, "_data"}, b_data, 64'd0);
    endtask

    task automatic mon_big();
        beat_t cur, hv, e;
        bit    hp;
        hp = 1'b0;
        forever begin
            @(negedge clk);
            if (b_valid) begin
                cur = {b_kind, b_index, b_data};
                if (hp) chk("big_hold", cur, hv);
                if (b_ready) begin
                    hp = 1'b0;
                    nb++;
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL big_unexpected: got beat %0h expected none", cur);
                    end else begin
                        e = qb.pop_front();
                        chk("big_beat", cur, e);
                    end
                end else begin
                    hp = 1'b1;
                    hv = cur;
                end
            end else begin
                hp = 1'b0;
            end
        end
    endtask

    task automatic mon_small();
        beat_t cur, e;
        forever begin
            @(negedge clk);
            if (s_valid && s_ready) begin
                cur = {s_kind, s_index, s_data};
                ns++;
                if (qs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL small_unexpected: got beat %0h expected none", cur);
                end else begin
                    e = qs.pop_front();
                    chk("small_beat", cur, e);
                end
            end
        end
    endtask

    // Called at posedge+1. n counts edges after the edge that samples start.
    task automatic run_big(input bit rnd, input int restart_at, input int abort_at, input int rst_at);
        int n;
        bit got;
        bit seen;
        n = 0; got = 1'b0; nb = 0;
        for (int i = 0; i < 32; i++) qb.push_back({DUMP_KIND_REG, 8'(i), rf[i]});
        for (int i = 0; i < 64; i++) qb.push_back({DUMP_KIND_MEM, 8'(i), mem[i]});
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        while (n < 2000 && !got) begin
            b_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            b_start = (n == restart_at);
            b_abort = (n == abort_at);
            if (n == restart_at) chk("restart_point", {b_kind, b_index, b_valid}, {1'b0, 8'd5, 1'b1});
            if (n == abort_at) begin
                b_ready = 1'b1;
                chk("abort_point", {b_kind, b_index, b_valid}, {1'b1, 8'd10, 1'b1});
            end
            if (!rnd && n == 66 && rst_at < 0)
                chk("mem_rd_word1", {b_mrd, b_full, b_own, b_maddr}, {3'b111, 32'd4});
            if (n == rst_at) begin
                chk("rst_point", {b_own, b_raddr, b_valid}, {1'b1, 5'd2, 1'b0});
                #1 b_rstn = 1'b0;
                #1 chk_big_zero("async_reset");
                qb.delete();
                @(posedge clk); #1;
                b_rstn = 1'b1;
                repeat (4) @(posedge clk);
                #1 chk("post_reset_idle", {b_busy, b_valid, b_own, b_done}, 64'd0);
                return;
            end
            @(posedge clk); #1;
            n++;
            b_abort = 1'b0;
            if (abort_at >= 0 && n == abort_at + 1) begin
                chk("abort_next", {b_busy, b_valid, b_own}, 64'd0);
                qb.delete();
                seen = 1'b0;
                repeat (20) begin
                    if (b_done) seen = 1'b1;
                    @(posedge clk); #1;
                end
                chk("abort_no_done", seen, 64'd0);
                return;
            end
            got = b_done;
        end
        if (!rnd) chk("big_done_edge", n, 2 * (32 + 64));
        chk("big_got_done", got, 64'd1);
        chk("big_beats", nb, 96);
        chk("big_q_empty", qb.size(), 0);
        b_ready = 1'b1;
        @(posedge clk); #1;
        chk("big_done_pulse", {b_done, b_busy}, 64'd0);
    endtask

    task automatic run_small();
        int n;
        bit got;
        n = 0; got = 1'b0; ns = 0;
        qs.push_back({DUMP_KIND_REG, 8'd0, rf[0]});
        qs.push_back({DUMP_KIND_MEM, 8'd0, mem[0]});
        s_ready = 1'b1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        while (n < 50 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) chk("small_mem_rd", {s_mrd, s_full, s_maddr}, {2'b11, 32'd0});
            got = s_done;
        end
        chk("small_done_edge", n, 4);
        chk("small_beats", ns, 2);
        chk("small_q_empty", qs.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0100_0000 | 32'(i);
        rf[0]  = 32'd0;
        rf[16] = 32'd2;
        rf[17] = 32'd5;
        rf[18] = 32'hFFFF_FFFD;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i * 3);
        mem[0] = 32'hCAFE_0001;
        mem[1] = 32'h0000_002A;
        b_rstn = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
        s_rstn = 1'b0; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
        fork
            mon_big();
            mon_small();
        join_none
        repeat (2) @(posedge clk);
        #1 chk_big_zero("reset");
        chk("small_reset", {s_busy, s_own, s_valid, s_done, s_mrd, s_full, s_data}, 64'd0);
        b_rstn = 1'b1;
        s_rstn = 1'b1;
        b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_ready_noop", {b_busy, b_valid, b_own}, 64'd0);
        b_start = 1'b1;
        b_abort = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_abort = 1'b0;
        chk("start_abort_idle", {b_busy, b_own, b_valid}, 64'd0);
        @(posedge clk); #1;

        run_big(1'b0, -1, -1, -1);
        run_big(1'b1, -1, -1, -1);
        run_big(1'b0, 11, -1, -1);
        run_big(1'b0, -1, 85, -1);
        run_big(1'b0, -1, -1, -1);
        run_big(1'b0, -1, -1, 4);
        run_small();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
